// File: rtl/pe_dot_accumulator.sv
// Per-lane block-floating-point accumulator behind the dot-product stage.
// Aligns each incoming dot result to a running exponent, accumulates with
// saturation across first/last delimited sequences, and queues results.
//
// Ports:
//   clock, resetn      rising-edge clock, async active-low reset
//   i_valid            input block present (no back-pressure)
//   i_first, i_last    sequence delimiters
//   i_dot, i_exp       per-lane dot results / block exponents, lane 0 in LSBs
//   o_valid, i_ready   output FIFO head handshake
//   o_acc, o_exp       FIFO head: per-lane sums and exponents
//   o_drop             sticky: result lost to a full FIFO
//   o_seq_err          sticky: first/last sequencing violated
module pe_dot_accumulator #(
    parameter int NUM_LANES  = 4,
    parameter int DOT_WIDTH  = 24,
    parameter int EXP_WIDTH  = 6,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           i_valid,
    input  logic                           i_first,
    input  logic                           i_last,
    input  logic [NUM_LANES*DOT_WIDTH-1:0] i_dot,
    input  logic [NUM_LANES*EXP_WIDTH-1:0] i_exp,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [NUM_LANES*ACC_WIDTH-1:0] o_acc,
    output logic [NUM_LANES*EXP_WIDTH-1:0] o_exp,
    output logic                           o_drop,
    output logic                           o_seq_err
);

    localparam int NL = NUM_LANES;
    localparam int DW = DOT_WIDTH;
    localparam int EW = EXP_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic signed [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state_q;

    logic signed [AW-1:0] acc_q  [NL];
    logic [EW-1:0]        aexp_q [NL];
    logic signed [AW-1:0] acc_d  [NL];
    logic [EW-1:0]        aexp_d [NL];

    // One guard bit so the sum can be checked for overflow before clamping.
    logic signed [AW:0]   dot_x  [NL];
    logic signed [AW:0]   acc_x  [NL];
    logic signed [AW:0]   sum_x  [NL];
    logic [EW-1:0]        e_in   [NL];
    logic [EW-1:0]        sh     [NL];
    logic                 up     [NL];

    logic [NL*AW-1:0] acc_flat;
    logic [NL*EW-1:0] exp_flat;

    logic start;
    logic seq_bad;

    assign start   = i_first | (state_q == IDLE);
    assign seq_bad = i_valid & ((i_first & (state_q == ACCUM)) |
                                (!i_first & (state_q == IDLE)));

    always_comb begin
        acc_flat = '0;
        exp_flat = '0;
        for (int l = 0; l < NL; l++) begin
            e_in[l]  = i_exp[l*EW +: EW];
            dot_x[l] = {{(AW+1-DW){i_dot[l*DW+DW-1]}}, i_dot[l*DW +: DW]};
            acc_x[l] = {acc_q[l][AW-1], acc_q[l]};
            up[l]    = e_in[l] > aexp_q[l];
            sh[l]    = up[l] ? (e_in[l] - aexp_q[l]) : (aexp_q[l] - e_in[l]);

            // The operand with the smaller exponent is shifted right (floor);
            // shifts past the width collapse to 0 or -1.
            if (start) begin
                sum_x[l]  = dot_x[l];
                aexp_d[l] = e_in[l];
            end else if (up[l]) begin
                sum_x[l]  = (acc_x[l] >>> sh[l]) + dot_x[l];
                aexp_d[l] = e_in[l];
            end else begin
                sum_x[l]  = acc_x[l] + (dot_x[l] >>> sh[l]);
                aexp_d[l] = aexp_q[l];
            end

            if (sum_x[l][AW] != sum_x[l][AW-1]) begin
                acc_d[l] = sum_x[l][AW] ? SMIN : SMAX;
            end else begin
                acc_d[l] = sum_x[l][AW-1:0];
            end

            acc_flat[l*AW +: AW] = acc_d[l];
            exp_flat[l*EW +: EW] = aexp_d[l];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            o_seq_err <= 1'b0;
            for (int l = 0; l < NL; l++) begin
                acc_q[l]  <= '0;
                aexp_q[l] <= '0;
            end
        end else if (i_valid) begin
            state_q <= i_last ? IDLE : ACCUM;
            if (seq_bad) begin
                o_seq_err <= 1'b1;
            end
            for (int l = 0; l < NL; l++) begin
                acc_q[l]  <= acc_d[l];
                aexp_q[l] <= aexp_d[l];
            end
        end
    end

    // Output FIFO; head is read straight from the storage registers.
    logic [NL*AW-1:0] mem_acc_q [FIFO_DEPTH];
    logic [NL*EW-1:0] mem_exp_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;

    logic push;
    logic pop;
    logic full;
    logic push_ok;

    assign o_valid = (cnt_q != '0);
    assign o_acc   = mem_acc_q[rd_q];
    assign o_exp   = mem_exp_q[rd_q];

    assign full    = (cnt_q == DEPTH_C);
    assign pop     = o_valid & i_ready;
    assign push    = i_valid & i_last;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (!full | pop);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            o_drop <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_acc_q[i] <= '0;
                mem_exp_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_acc_q[wr_q] <= acc_flat;
                mem_exp_q[wr_q] <= exp_flat;
                wr_q            <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push & !push_ok) begin
                o_drop <= 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_dot_accumulator.sv
// Randomized + directed bench for pe_dot_accumulator against an
// integer-arithmetic reference model with a queue-based output FIFO.
module tb_pe_dot_accumulator;

    localparam int NL = 4;
    localparam int DW = 24;
    localparam int EW = 6;
    localparam int AW = 32;
    localparam int FD = 4;

    localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW-1));

    logic              clock;
    logic              resetn;
    logic              i_valid;
    logic              i_first;
    logic              i_last;
    logic [NL*DW-1:0]  i_dot;
    logic [NL*EW-1:0]  i_exp;
    logic              o_valid;
    logic              i_ready;
    logic [NL*AW-1:0]  o_acc;
    logic [NL*EW-1:0]  o_exp;
    logic              o_drop;
    logic              o_seq_err;

    pe_dot_accumulator #(
        .NUM_LANES (NL),
        .DOT_WIDTH (DW),
        .EXP_WIDTH (EW),
        .ACC_WIDTH (AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .i_valid  (i_valid),
        .i_first  (i_first),
        .i_last   (i_last),
        .i_dot    (i_dot),
        .i_exp    (i_exp),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_acc    (o_acc),
        .o_exp    (o_exp),
        .o_drop   (o_drop),
        .o_seq_err(o_seq_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [NL*AW-1:0] a;
        logic [NL*EW-1:0] e;
    } res_t;

    longint m_acc [NL];
    int     m_exp [NL];
    bit     m_open;
    bit     m_drop;
    bit     m_seq;
    res_t   m_q [$];

    function automatic longint asr(input longint x, input int s);
        longint p;
        longint q;
        if (s >= 62) return (x < 0) ? -1 : 0;
        p = longint'(1) << s;
        q = x / p;
        if (x < 0 && q * p != x) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint x);
        if (x > AMAX) return AMAX;
        if (x < AMIN) return AMIN;
        return x;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_open = 0;
        m_drop = 0;
        m_seq  = 0;
        for (int l = 0; l < NL; l++) begin
            m_acc[l] = 0;
            m_exp[l] = 0;
        end
    endtask

    task automatic model_step(input bit v, f, l, input logic [NL*DW-1:0] dots,
                              input logic [NL*EW-1:0] exps, input bit rdy);
        res_t r;
        longint d;
        int e;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (v) begin
            if ((f && m_open) || (!f && !m_open)) m_seq = 1;
            for (int k = 0; k < NL; k++) begin
                d = longint'(dots[k*DW +: DW]);
                if (d >= (longint'(1) << (DW-1))) d = d - (longint'(1) << DW);
                e = int'(exps[k*EW +: EW]);
                if (f || !m_open) begin
                    m_acc[k] = d;
                    m_exp[k] = e;
                end else if (e > m_exp[k]) begin
                    m_acc[k] = sat(asr(m_acc[k], e - m_exp[k]) + d);
                    m_exp[k] = e;
                end else begin
                    m_acc[k] = sat(m_acc[k] + asr(d, m_exp[k] - e));
                end
                r.a[k*AW +: AW] = m_acc[k][AW-1:0];
                r.e[k*EW +: EW] = m_exp[k][EW-1:0];
            end
            if (l) begin
                if (m_q.size() < FD) m_q.push_back(r);
                else m_drop = 1;
            end
            m_open = !l;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".valid"}, 128'(o_valid), 128'(m_q.size() > 0));
        check({tag, ".drop"}, 128'(o_drop), 128'(m_drop));
        check({tag, ".seq"}, 128'(o_seq_err), 128'(m_seq));
        if (m_q.size() > 0) begin
            check({tag, ".acc"}, 128'(o_acc), 128'(m_q[0].a));
            check({tag, ".exp"}, 128'(o_exp), 128'(m_q[0].e));
        end
    endtask

    task automatic step(input string tag, input bit v, f, l,
                        input logic [NL*DW-1:0] dots,
                        input logic [NL*EW-1:0] exps, input bit rdy);
        @(negedge clock);
        i_valid = v;
        i_first = f;
        i_last  = l;
        i_dot   = dots;
        i_exp   = exps;
        i_ready = rdy;
        @(posedge clock);
        model_step(v, f, l, dots, exps, rdy);
        #1;
        compare(tag);
    endtask

    function automatic logic [NL*DW-1:0] rd(input logic [DW-1:0] v);
        return {NL{v}};
    endfunction

    function automatic logic [NL*EW-1:0] re(input logic [EW-1:0] v);
        return {NL{v}};
    endfunction

    function automatic logic [NL*DW-1:0] rnd_dot();
        logic [NL*DW-1:0] x;
        for (int k = 0; k < NL; k++) x[k*DW +: DW] = $urandom;
        return x;
    endfunction

    function automatic logic [NL*EW-1:0] rnd_exp();
        logic [NL*EW-1:0] x;
        for (int k = 0; k < NL; k++) begin
            if ($urandom_range(0, 9) == 0) x[k*EW +: EW] = $urandom;
            else x[k*EW +: EW] = EW'($urandom_range(0, 7));
        end
        return x;
    endfunction

    task automatic idle(input string tag, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, '0, '0, rdy);
    endtask

    initial begin
        resetn  = 1'b0;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_dot   = '0;
        i_exp   = '0;
        i_ready = 1'b0;
        model_reset();
        #12;
        check("rst.valid", 128'(o_valid), 128'(0));
        check("rst.acc", 128'(o_acc), 128'(0));
        check("rst.exp", 128'(o_exp), 128'(0));
        check("rst.drop", 128'(o_drop), 128'(0));
        check("rst.seq", 128'(o_seq_err), 128'(0));
        @(negedge clock);
        resetn = 1'b1;

        step("seq1", 1, 1, 0, rd(24'd10), re(0), 1);
        step("seq1", 1, 0, 0, rd(24'd20), re(0), 1);
        step("seq1", 1, 0, 1, rd(24'd30), re(0), 1);
        check("seq1.sum", 128'(o_acc), {4{32'd60}});
        idle("seq1", 2, 1);

        step("align", 1, 1, 0, rd(24'd100), re(2), 1);
        step("align", 1, 0, 0, rd(24'd8), re(4), 1);
        step("align", 1, 0, 1, rd(-24'sd13), re(3), 1);
        check("align.sum", 128'(o_acc), {4{32'd26}});
        check("align.exp", 128'(o_exp), 128'(re(4)));
        idle("align", 1, 1);

        for (int i = 0; i < 300; i++)
            step("satp", 1, i == 0, i == 299, rd(24'h7FFFFF), re(0), 1);
        check("satp.sum", 128'(o_acc), {4{32'h7FFFFFFF}});
        for (int i = 0; i < 300; i++)
            step("satn", 1, i == 0, i == 299, rd(24'h800001), re(0), 1);
        check("satn.sum", 128'(o_acc), {4{32'h80000000}});
        idle("satn", 1, 1);

        for (int i = 0; i < 8; i++)
            step("full", 1, 1, 1, rnd_dot(), rnd_exp(), 0);
        check("full.drop", 128'(o_drop), 128'(1));
        idle("drain", 6, 1);

        step("seqe", 1, 0, 0, rd(24'd5), re(1), 1);
        step("seqe", 1, 0, 0, rd(24'd7), re(1), 1);
        step("seqe", 1, 1, 0, rd(24'd3), re(0), 1);
        step("seqe", 1, 0, 1, rd(24'd4), re(0), 1);
        check("seqe.sum", 128'(o_acc), {4{32'd7}});
        idle("seqe", 2, 1);

        step("mrst", 1, 1, 1, rnd_dot(), rnd_exp(), 0);
        step("mrst", 1, 1, 1, rnd_dot(), rnd_exp(), 0);
        step("mrst", 1, 1, 0, rnd_dot(), rnd_exp(), 0);
        @(negedge clock);
        i_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        compare("mrst.async");
        @(negedge clock);
        resetn = 1'b1;
        step("post", 1, 1, 0, rd(24'd1), re(0), 1);
        step("post", 1, 0, 1, rd(24'd2), re(0), 1);
        check("post.sum", 128'(o_acc), {4{32'd3}});
        idle("post", 1, 1);

        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(0, 5) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, rnd_dot(), rnd_exp(),
                 $urandom_range(0, 3) != 0);
        end
        idle("tail", 6, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pe_dot_accumulator.md
# pe_dot_accumulator

Downstream consumer of the DSP dot-product stage. Each cycle it takes one block of NUM_LANES signed dot results (one per feature/filter pair) with per-lane block exponents, aligns each to a running per-lane exponent, and accumulates across a sequence of blocks delimited by first/last flags. Completed sums are pushed into a small output FIFO drained with a valid/ready handshake. The dot stage cannot stall, so the input side has no ready; overflow of the FIFO is flagged, not back-pressured.

## Interface
- NUM_LANES, 4, parallel accumulators (NUM_FEATURES*NUM_FILTERS, lane = feature*NUM_FILTERS+filter)
- DOT_WIDTH, 24, two's-complement width of each incoming dot result
- EXP_WIDTH, 6, unsigned block-exponent width
- ACC_WIDTH, 32, two's-complement accumulator width (>= DOT_WIDTH)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)

- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- i_valid  in  1  input block present this cycle
- i_first  in  1  block starts a new accumulation
- i_last  in  1  block ends the accumulation
- i_dot  in  NUM_LANES*DOT_WIDTH  dot results, lane 0 in LSBs
- i_exp  in  NUM_LANES*EXP_WIDTH  block exponent per lane (feature exp + filter exp)
- o_valid  out  1  FIFO head valid
- i_ready  in  1  consumer accepts head
- o_acc  out  NUM_LANES*ACC_WIDTH  accumulated sums, lane 0 in LSBs
- o_exp  out  NUM_LANES*EXP_WIDTH  exponent of each sum
- o_drop  out  1  sticky: a result was lost to a full FIFO
- o_seq_err  out  1  sticky: first/last sequencing violated

## Operation
- Two-state control: IDLE (no open accumulation), ACCUM (open). Reset -> IDLE.
- Accept = i_valid. Inputs ignored when i_valid=0.
- Per lane on accept, with d = sign-extended i_dot, e = i_exp:
  - start (i_first, or IDLE): acc <= d, acc_exp <= e.
  - e > acc_exp: acc <= sat(acc >>> (e-acc_exp) + d), acc_exp <= e.
  - e <= acc_exp: acc <= sat(acc + (d >>> (acc_exp-e))), acc_exp unchanged.
  - >>> is arithmetic (floor); shift >= ACC_WIDTH yields 0 or -1 by sign.
  - sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; computed at ACC_WIDTH+1 bits.
- Transitions: accept & i_last -> IDLE and push the just-computed {acc, acc_exp} (all lanes) into FIFO; accept & !i_last -> ACCUM.
- i_first & i_last together: single-block result (acc = d, exp = e).
- i_first while ACCUM: partial sum discarded, restart from d, o_seq_err set.
- Accept without i_first while IDLE: treated as start, o_seq_err set.
- FIFO push when full: result discarded, o_drop set, FIFO contents unchanged. Push and pop in the same cycle on a full FIFO: pop first, push succeeds, no drop.
- Pop when o_valid & i_ready. o_acc/o_exp stable while o_valid & !i_ready.
- o_drop, o_seq_err cleared only by resetn.

## Timing
- Reset (async assert, synchronous release sampled at next edge): state IDLE, acc/acc_exp 0, FIFO empty, o_valid 0, o_acc 0, o_exp 0, o_drop 0, o_seq_err 0.
- Accumulate is single-cycle: back-to-back accepts every cycle, no bubbles.
- Latency: accept with i_last in cycle t -> o_valid=1 in cycle t+1 when FIFO was empty.
- Sticky flags assert in cycle t+1 after the offending accept.
- o_valid, o_acc, o_exp driven from registers (FIFO head), no combinational path from i_valid or i_ready.
- Throughput: sustained one result per cycle when i_ready=1.

## Test plan
- Reset then one lane sequence dot={10,20,30}, exp={0,0,0}, first on 1st, last on 3rd -> single o_valid one cycle after 3rd, o_acc=60, o_exp=0; flags 0.
- Alignment: blocks (dot=100,e=2),(dot=8,e=4),(dot=-13,e=3) -> 100>>>2=25+8=33, then 33+(-13>>>1=-7)=26, o_exp=4.
- Saturation: ACC_WIDTH=32 lane, repeat dot=2^23-1 at e=0 for 300 blocks -> o_acc=2^31-1 (no wrap); negative mirror -> -2^31.
- i_first&i_last every cycle for 8 cycles, i_ready=0 -> 4 entries held, o_drop=1 from 5th, head unchanged; then i_ready=1 -> first 4 results in order, o_valid drops.
- Sequencing: accept without first in IDLE and first mid-ACCUM -> o_seq_err=1, results equal restarted sums.
- resetn asserted mid-ACCUM with FIFO holding 2 entries -> immediately o_valid=0, FIFO empty; next sequence after release produces correct sum from clean start.
